gate_test_sequencer: RTL and testbench

Self-test controller for a small combinational gate under test, e.g. the 2-input AND cell.
- On `start`, walks every input combination onto the gate's inputs in ascending binary order.
- Waits a fixed settle time, samples the gate output and compares it against an expected truth table.
- Accumulates a failure count and a per-vector failure mask.
- Replaces hand-written delay/compare benches with a reusable, synthesizable sequencer that sits beside the gate in test harnesses.

---
 rtl/gate_test_sequencer.sv | 139 +++++++++++++
 tb/tb_gate_test_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
// Self-test sequencer: walks every input vector onto a small combinational gate,
// waits a fixed settle time, and checks the sampled output against a truth table.
module gate_test_sequencer #(
   parameter int                    N_IN   = 2,
   parameter int                    SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0]  EXPECT = 4'b1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [N_IN-1:0]        dut_in,
   input  logic                   dut_out,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [N_IN:0]          fail_count,
   output logic [(1<<N_IN)-1:0]   fail_mask
);

   localparam int V  = 1 << N_IN;
   // Settle counter only needs to reach SETTLE-1.
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [N_IN-1:0]     vec_q, vec_d;
   logic [SW-1:0]       cnt_q, cnt_d;
   logic [N_IN-1:0]     dut_in_q, dut_in_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [N_IN:0]       fail_count_q, fail_count_d;
   logic [V-1:0]        fail_mask_q, fail_mask_d;
   logic                exp_bit;
   logic                mismatch;

   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      cnt_d        = cnt_q;
      dut_in_d     = dut_in_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      pass_d       = pass_q;
      fail_count_d = fail_count_q;
      fail_mask_d  = fail_mask_q;
      exp_bit      = EXPECT[vec_q];
      mismatch     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_APPLY;
               busy_d       = 1'b1;
               pass_d       = 1'b0;
               fail_count_d = '0;
               fail_mask_d  = '0;
               vec_d        = '0;
            end
         end
         S_APPLY: begin
            dut_in_d = vec_q;
            cnt_d    = '0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SAMPLE: begin
            // Case inequality so an X/Z gate output is flagged in simulation.
            mismatch = (dut_out !== exp_bit);
            if (mismatch) begin
               fail_count_d       = fail_count_q + 1'b1;
               fail_mask_d[vec_q] = 1'b1;
            end
            if (vec_q == {N_IN{1'b1}}) begin
               state_d = S_DONE;
            end else begin
               vec_d   = vec_q + 1'b1;
               state_d = S_APPLY;
            end
         end
         S_DONE: begin
            // fail_count_q already includes the last vector's result here.
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (fail_count_q == '0);
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         vec_q        <= '0;
         cnt_q        <= '0;
         dut_in_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_count_q <= '0;
         fail_mask_q  <= '0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         cnt_q        <= cnt_d;
         dut_in_q     <= dut_in_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         fail_count_q <= fail_count_d;
         fail_mask_q  <= fail_mask_d;
      end
   end

   assign dut_in     = dut_in_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail_count = fail_count_q;
   assign fail_mask  = fail_mask_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: three parameterisations driven by simple gate
// models, with expected run results queued at start and checked at done.
module tb_gate_test_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Instance a: defaults (2-input, settle 2, AND table)
   logic       start_a = 1'b0, out_a, busy_a, done_a, pass_a;
   logic [1:0] in_a;
   logic [2:0] fc_a;
   logic [3:0] fm_a;
   // Instance b: OR truth table
   logic       start_b = 1'b0, out_b, busy_b, done_b, pass_b;
   logic [1:0] in_b;
   logic [2:0] fc_b;
   logic [3:0] fm_b;
   // Instance c: 3-input AND, settle 1
   logic       start_c = 1'b0, out_c, busy_c, done_c, pass_c;
   logic [2:0] in_c;
   logic [3:0] fc_c;
   logic [7:0] fm_c;

   int mode_a = 0;   // 0 AND, 1 tie0, 2 tie1, 3 OR
   int mode_c = 0;   // 0 AND3, 4 AND3 with vector 5 faulty

   gate_test_sequencer u_a (
      .clk(clk), .rst(rst), .start(start_a), .dut_in(in_a), .dut_out(out_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a), .fail_mask(fm_a));

   gate_test_sequencer #(.N_IN(2), .SETTLE(2), .EXPECT(4'b1110)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .dut_in(in_b), .dut_out(out_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b), .fail_mask(fm_b));

   gate_test_sequencer #(.N_IN(3), .SETTLE(1), .EXPECT(8'b1000_0000)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .dut_in(in_c), .dut_out(out_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .fail_count(fc_c), .fail_mask(fm_c));

   always_comb begin
      case (mode_a)
         1:       out_a = 1'b0;
         2:       out_a = 1'b1;
         3:       out_a = in_a[1] | in_a[0];
         default: out_a = in_a[1] & in_a[0];
      endcase
   end
   assign out_b = in_b[1] | in_b[0];
   assign out_c = (in_c[2] & in_c[1] & in_c[0]) ^ ((mode_c == 4) && (in_c == 3'd5));

   // Selected-instance view
   int         sel = 0;
   logic       cur_busy, cur_done, cur_pass;
   logic [2:0] cur_in;
   logic [3:0] cur_fc;
   logic [7:0] cur_fm;
   always_comb begin
      cur_busy = busy_a; cur_done = done_a; cur_pass = pass_a;
      cur_in = {1'b0, in_a}; cur_fc = {1'b0, fc_a}; cur_fm = {4'b0, fm_a};
      if (sel == 1) begin
         cur_busy = busy_b; cur_done = done_b; cur_pass = pass_b;
         cur_in = {1'b0, in_b}; cur_fc = {1'b0, fc_b}; cur_fm = {4'b0, fm_b};
      end else if (sel == 2) begin
         cur_busy = busy_c; cur_done = done_c; cur_pass = pass_c;
         cur_in = in_c; cur_fc = fc_c; cur_fm = fm_c;
      end
   end

   task automatic set_start(input logic v);
      if (sel == 0) start_a = v;
      else if (sel == 1) start_b = v;
      else start_c = v;
   endtask

   typedef struct {
      string      name;
      int         lat;
      logic       pass;
      logic [3:0] fc;
      logic [7:0] fm;
   } exp_t;
   exp_t sb[$];

   // Wait (bounded) for done; returns cycles since t0 and whether it arrived.
   task automatic wait_done(input int t0, input int x1, input int x2, input bit steps,
                            output int k, output bit got);
      got = 1'b0;
      k   = 0;
      while (!got && k < 80) begin
         @(negedge clk);
         k = cyc - t0;
         set_start((k == x1 || k == x2) ? 1'b1 : 1'b0);
         if (steps && (k == 1 || k == 5 || k == 9 || k == 13)) begin
            checks++;
            if (cur_in !== 3'((k - 1) / 4)) begin
               errors++;
               $display("FAIL dut_in_step k=%0d got %0d want %0d", k, cur_in, (k - 1) / 4);
            end
         end
         if (cur_done === 1'b1) got = 1'b1;
      end
      set_start(1'b0);
   endtask

   task automatic check_result(input int k, input bit got);
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout got no done want done at %0d", e.name, e.lat);
         return;
      end
      checks++;
      if (k != e.lat) begin
         errors++; $display("FAIL %s latency got %0d want %0d", e.name, k, e.lat);
      end
      checks++;
      if (cur_pass !== e.pass) begin
         errors++; $display("FAIL %s pass got %b want %b", e.name, cur_pass, e.pass);
      end
      checks++;
      if (cur_fc !== e.fc) begin
         errors++; $display("FAIL %s fail_count got %0d want %0d", e.name, cur_fc, e.fc);
      end
      checks++;
      if (cur_fm !== e.fm) begin
         errors++; $display("FAIL %s fail_mask got %b want %b", e.name, cur_fm, e.fm);
      end
      checks++;
      if (cur_busy !== 1'b0) begin
         errors++; $display("FAIL %s busy_at_done got %b want 0", e.name, cur_busy);
      end
      $display("run %s: latency %0d pass %b fail_count %0d fail_mask %b",
               e.name, k, cur_pass, cur_fc, cur_fm);
   endtask

   task automatic run_check(input string nm, input int lat, input logic ep,
                            input logic [3:0] efc, input logic [7:0] efm,
                            input int x1, input int x2, input bit steps);
      int t0, k, extra;
      bit got;
      exp_t e;
      e.name = nm; e.lat = lat; e.pass = ep; e.fc = efc; e.fm = efm;
      sb.push_back(e);
      @(negedge clk); set_start(1'b1);
      @(negedge clk); set_start(1'b0);
      t0 = cyc;
      checks++;
      if (cur_busy !== 1'b1) begin
         errors++; $display("FAIL %s busy_after_start got %b want 1", nm, cur_busy);
      end
      wait_done(t0, x1, x2, steps, k, got);
      check_result(k, got);
      // done is a single pulse, pass holds, and nothing restarts.
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cur_done === 1'b1 || cur_busy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++; $display("FAIL %s extra_activity got %0d want 0", nm, extra);
      end
      checks++;
      if (cur_pass !== ep) begin
         errors++; $display("FAIL %s pass_hold got %b want %b", nm, cur_pass, ep);
      end
   endtask

   task automatic test_reset;
      sel = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({cur_in, cur_busy, cur_done, cur_pass, cur_fc, cur_fm} !== '0 ||
          {in_c, busy_c, done_c, pass_c, fc_c, fm_c} !== '0) begin
         errors++;
         $display("FAIL reset_state got in=%0d busy=%b done=%b pass=%b fc=%0d fm=%b want all 0",
                  cur_in, cur_busy, cur_done, cur_pass, cur_fc, cur_fm);
      end
      $display("reset: outputs in=%0d busy=%b fc=%0d fm=%b", cur_in, cur_busy, cur_fc, cur_fm);
      rst = 1'b0;
   endtask

   task automatic test_and_gate;
      sel = 0; mode_a = 0;
      run_check("and_default", 17, 1'b1, 4'd0, 8'h00, -1, -1, 1'b1);
   endtask

   task automatic test_tied_outputs;
      sel = 0;
      mode_a = 1;
      run_check("tie0", 17, 1'b0, 4'd1, 8'b0000_1000, -1, -1, 1'b0);
      mode_a = 2;
      run_check("tie1", 17, 1'b0, 4'd3, 8'b0000_0111, -1, -1, 1'b0);
   endtask

   task automatic test_or_gate;
      sel = 0; mode_a = 3;
      run_check("or_vs_and", 17, 1'b0, 4'd2, 8'b0000_0110, -1, -1, 1'b0);
      sel = 1;
      run_check("or_vs_or", 17, 1'b1, 4'd0, 8'h00, -1, -1, 1'b0);
   endtask

   task automatic test_ignored_start;
      sel = 0; mode_a = 2;
      run_check("ignored_start", 17, 1'b0, 4'd3, 8'b0000_0111, 3, 10, 1'b0);
      mode_a = 0;
      run_check("clear_after_fail", 17, 1'b1, 4'd0, 8'h00, -1, -1, 1'b0);
   endtask

   task automatic test_back_to_back;
      int t0, k;
      bit got;
      exp_t e;
      sel = 0; mode_a = 0;
      e.name = "b2b_first"; e.lat = 17; e.pass = 1'b1; e.fc = 4'd0; e.fm = 8'h00;
      sb.push_back(e);
      e.name = "b2b_second";
      sb.push_back(e);
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); t0 = cyc;
      got = 1'b0; k = 0;
      while (!got && k < 80) begin
         @(negedge clk); k = cyc - t0;
         if (done_a === 1'b1) got = 1'b1;
      end
      check_result(k, got);
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b1 || done_a !== 1'b0) begin
         errors++; $display("FAIL b2b_retrigger got busy=%b done=%b want busy=1 done=0", busy_a, done_a);
      end
      t0 = cyc;
      start_a = 1'b0;
      wait_done(t0, -1, -1, 1'b0, k, got);
      check_result(k, got);
   endtask

   task automatic test_reset_mid_run;
      int t0, k, dones;
      sel = 0; mode_a = 0;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      t0 = cyc; k = 0;
      while (k < 10) begin
         @(negedge clk); k = cyc - t0;
      end
      checks++;
      if (in_a !== 2'd2) begin
         errors++; $display("FAIL pre_reset_vector got %0d want 2", in_a);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({in_a, busy_a, done_a, pass_a, fc_a, fm_a} !== '0) begin
         errors++;
         $display("FAIL async_reset got in=%0d busy=%b done=%b pass=%b fc=%0d fm=%b want all 0",
                  in_a, busy_a, done_a, pass_a, fc_a, fm_a);
      end
      $display("mid-run reset: in=%0d busy=%b done=%b", in_a, busy_a, done_a);
      dones = 0;
      repeat (3) begin
         @(negedge clk);
         if (done_a === 1'b1) dones++;
      end
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done_a === 1'b1 || busy_a === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++; $display("FAIL reset_no_done got %0d want 0", dones);
      end
      run_check("after_reset", 17, 1'b1, 4'd0, 8'h00, -1, -1, 1'b0);
   endtask

   task automatic test_three_input;
      sel = 2;
      mode_c = 0;
      run_check("and3", 25, 1'b1, 4'd0, 8'h00, -1, -1, 1'b0);
      mode_c = 4;
      run_check("and3_fault5", 25, 1'b0, 4'd1, 8'b0010_0000, -1, -1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_and_gate();
      test_tied_outputs();
      test_or_gate();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid_run();
      test_three_input();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
